// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for the MIPS R2000 pipeline.
// Radix-2 shift-add multiply and restoring divide on absolute values,
// followed by one sign-correction cycle (FIX), so every mult/div takes WIDTH+1 cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no computation in flight; accepts mult/div/MTHI/MTLO
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring divide iteration, one quotient bit per cycle
// FIX   | sign correction and HI/LO writeback, then done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: low half = dividend/quotient
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   rs_raw;    // raw dividend, returned unchanged on divide by zero
  logic               neg_lo;    // product sign (mul) or quotient sign (div)
  logic               neg_hi;    // remainder sign (div only)
  logic               is_div;
  logic               div_zero;

  logic               accept;
  logic               is_md;
  logic               signed_op;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy  = (state != S_IDLE);
  assign stall = rd_req & busy;

  assign accept    = (state == S_IDLE) & start & ~flush;
  assign is_md     = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_DIV) | (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) | (op == OP_DIV);
  assign rs_abs    = (signed_op && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
  assign rt_abs    = (signed_op && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;

  // Per-iteration arithmetic and the FIX-stage sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_abs} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_abs});
    div_diff  = div_shift[WIDTH-1:0] - b_abs;
    prod_fix  = neg_lo ? (~acc + 1'b1) : acc;
    quot_fix  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix   = neg_hi ? (~rem + 1'b1) : rem;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush aborts any in-flight operation.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_md) state_nxt = op[1] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CW'(1))    state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, writeback and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      a_abs    <= '0;
      b_abs    <= '0;
      rs_raw   <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) hi <= rs_data;
            if (op == OP_MTLO) lo <= rs_data;
            if (is_md) begin
              cnt      <= CW'(WIDTH);
              is_div   <= op[1];
              a_abs    <= rs_abs;
              b_abs    <= rt_abs;
              rs_raw   <= rs_data;
              div_zero <= (rt_data == '0);
              neg_lo   <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              neg_hi   <= signed_op & op[1] & rs_data[WIDTH-1];
              rem      <= '0;
              acc      <= op[1] ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
            end
          end
        end
        S_MUL: begin
          cnt <= cnt - 1'b1;
          acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        S_DIV: begin
          cnt            <= cnt - 1'b1;
          rem            <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
        end
        S_FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= rs_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of the MIPS HI/LO operations.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         flush;
  logic         rd_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .rd_req(rd_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {hi, lo} produced by a mult/div op from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb, sq, sr;
    sa = a;
    sb = b;
    case (o)
      3'b000: begin sp = 64'(sa) * 64'(sb); return sp; end
      3'b001: begin up = {32'b0, a} * {32'b0, b}; return up; end
      3'b010: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one mult/div and check latency, stall, hold, done pulse and result.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic hold_rd, input string name);
    logic [63:0] r;
    int cyc;
    int stall_cnt;
    logic held_ok;
    r = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; rd_req = hold_rd;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; stall_cnt = 0; held_ok = 1'b1;
    while (busy && cyc < 100) begin
      cyc++;
      if (stall) stall_cnt++;
      if (hi !== exp_hi || lo !== exp_lo) held_ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 33) begin
      failures++;
      $display("FAIL %s latency: busy cycles=%0d expected=33", name, cyc);
    end
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL %s hold: hi/lo changed during computation", name);
    end
    if (hold_rd) begin
      checks++;
      if (stall_cnt !== 33 || stall !== 1'b0) begin
        failures++;
        $display("FAIL %s stall: stall cycles=%0d now=%b expected 33 then 0", name, stall_cnt, stall);
      end
    end
    checks++;
    if (done !== 1'b1 || hi !== r[63:32] || lo !== r[31:0]) begin
      failures++;
      $display("FAIL %s result: done=%b hi=%h lo=%h expected done=1 hi=%h lo=%h",
               name, done, hi, lo, r[63:32], r[31:0]);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  // Single-cycle move or no-op in IDLE.
  task automatic run_move(input logic [2:0] o, input logic [31:0] a, input string name);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'b100) exp_hi = a;
    if (o == 3'b101) exp_lo = a;
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s: hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
               name, hi, lo, busy, done, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0; flush = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || stall !== 0) begin
      failures++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b expected all 0", hi, lo, busy, done, stall);
    end
  endtask

  task automatic test_mult;
    run_md(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    run_md(3'b000, 32'hFFFFFFFD, 32'h00000005, 1'b1, "mult_neg3x5");
    run_md(3'b000, 32'h80000000, 32'h80000000, 1'b0, "mult_minmin");
  endtask

  task automatic test_div;
    run_md(3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b0, "div_neg7by2");
    run_md(3'b011, 32'd100, 32'd7, 1'b0, "divu_100by7");
    run_md(3'b011, 32'h00001234, 32'h0, 1'b0, "divu_by0");
    run_md(3'b010, 32'hFFFFFFF9, 32'h0, 1'b0, "div_neg_by0");
    run_md(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
    run_md(3'b010, 32'h00000007, 32'hFFFFFFFE, 1'b0, "div_7byneg2");
  endtask

  task automatic test_moves;
    run_move(3'b100, 32'h13572468, "mthi");
    run_move(3'b101, 32'h9ABCDEF0, "mtlo");
    run_move(3'b110, 32'hDEADBEEF, "noop6");
  endtask

  task automatic test_flush;
    int seen_done;
    run_move(3'b100, 32'hA5A5A5A5, "mthi_a5");
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs_data = 32'd2; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: busy=%b expected 0", busy);
    end
    seen_done = 0;
    repeat (40) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 0 || hi !== 32'hA5A5A5A5 || lo !== exp_lo) begin
      failures++;
      $display("FAIL flush_result: done pulses=%0d hi=%h lo=%h expected 0 hi=a5a5a5a5 lo=%h",
               seen_done, hi, lo, exp_lo);
    end
    // flush together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b101; rs_data = 32'h11111111;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || lo !== exp_lo) begin
      failures++;
      $display("FAIL flush_start: busy=%b lo=%h expected 0 lo=%h", busy, lo, exp_lo);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'b101; rs_data = 32'hDEADDEAD;
    @(negedge clk);
    op = 3'b011; rs_data = 32'd50; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    checks++;
    if (cyc !== 28 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
      failures++;
      $display("FAIL busy_ignore: cycles=%0d done=%b hi=%h lo=%h expected 28 1 0 2a", cyc, done, hi, lo);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd42;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    start = 1'b1; op = 3'b010; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    run_md(3'b001, 32'd6, 32'd7, 1'b0, "multu_after_reset");
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        3: a = 32'h80000000;
        default: ;
      endcase
      if (o < 3'd4) run_md(o, a, b, i[0], "random_md");
      else          run_move(o, a, "random_move");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_moves();
    test_flush();
    test_busy_ignore();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS R2000 pipeline.
- Sits beside the execute stage and consumes the operand pair (rs, rt) and the decoded mult/div operation that execute produces.
- Owns the architectural HI and LO registers and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises a stall request to the pipeline when an MFHI/MFLO reaches it while a computation is still in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation valid from execute, sampled at rising edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- rs_data  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- rt_data  input  WIDTH  multiplier / divisor
- flush  input  1  exception flush; aborts any in-flight operation
- rd_req  input  1  MFHI/MFLO present, wants HI/LO this cycle
- hi  output  WIDTH  architectural HI register
- lo  output  WIDTH  architectural LO register
- busy  output  1  computation in flight
- done  output  1  one-cycle pulse: HI/LO just updated by a mult/div
- stall  output  1  pipeline stall request

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous on rst_n low: state=IDLE, hi=0, lo=0, busy=0, done=0, and all internal accumulators are cleared. Reset asserted mid-operation abandons the operation immediately.
- State machine states: IDLE, MUL, DIV, FIX.
- IDLE, start=1, flush=0, op=MULT/MULTU/DIV/DIVU:
  - Latch operands.
  - For signed ops, store absolute values and the sign flags: product sign = rs[31]^rt[31]; quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
  - Unsigned ops use zero sign flags.
  - Load the iteration counter with WIDTH and move to MUL or DIV.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= rs_data at that edge; busy stays 0; done stays 0.
- MUL: radix-2 shift-add on a 2*WIDTH-bit accumulator, one multiplier bit per cycle, WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX:
  - Apply two's-complement negation per the stored sign flags. The 64-bit product is negated as a whole; quotient and remainder are negated independently.
  - Write {hi,lo}: product high/low for MUL; remainder to hi and quotient to lo for DIV.
  - done=1 for the following cycle; return to IDLE.
- Latency: start sampled at edge E0; busy=1 from E0 through E(WIDTH+1); hi/lo written at E(WIDTH+1) (E33 for WIDTH=32); busy=0 and done=1 in the cycle after that edge. Unsigned ops also pass through FIX, so the latency is uniform.
- hi/lo hold their old values throughout a computation.
- start while busy is ignored, including MTHI/MTLO.
- Divide by zero (rt_data=0, signed or unsigned): same 33-cycle latency; result lo=all ones, hi=rs_data (raw dividend, no sign correction).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- flush=1 in any non-IDLE state: return to IDLE at the next edge; hi/lo unchanged; no done pulse.
- flush=1 together with start in IDLE: start is ignored.
- stall = rd_req & busy, combinational. When rd_req arrives in the same cycle as done=1, stall=0 and the new hi/lo are visible.
- Arithmetic: all internal sums are WIDTH+1 bits wide; no overflow reaches hi/lo except as stated above.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 5 (0xFFFFFFFD, 0x00000005) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Holding rd_req=1 throughout gives stall=1 for 33 cycles, then 0.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 0x1234 / 0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5, then MULTU 2x3 started, then flush at cycle 10 -> busy=0 next cycle, no done pulse; hi=0xA5A5A5A5, lo unchanged. An MTLO issued while busy is ignored.
- rst_n pulsed low mid-DIV, asynchronously between clock edges -> hi=lo=0 and busy=0 immediately. A new MULTU 6x7 issued after reset gives lo=42, hi=0.
